key_led_avmm_pio: RTL

//  Avalon-MM slave peripheral that the Nios II master addresses to own keys and LEDs.

---
 rtl/key_led_avmm_pio.sv | 129 ++++++++++++
 1 files changed

// File: rtl/key_led_avmm_pio.sv
// Avalon-MM key/LED peripheral: synchronised, debounced active-low keys with a
// press edge-capture register, maskable level IRQ and an LED output register.
module key_led_avmm_pio #(
  parameter int unsigned KEY_W      = 1,
  parameter int unsigned LED_W      = 4,
  parameter int unsigned DEB_CYCLES = 2000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  input  logic [KEY_W-1:0]  key_n,
  output logic [LED_W-1:0]  led
);

  localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_LED  = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_ECAP = 2'd3;

  logic [KEY_W-1:0] r_sync1;
  logic [KEY_W-1:0] r_sync2;
  logic [KEY_W-1:0] r_stable;
  logic [CNT_W-1:0] r_cnt [KEY_W];
  logic [KEY_W-1:0] r_edge_cap;
  logic [KEY_W-1:0] r_mask;
  logic [LED_W-1:0] r_led;
  logic             r_irq;
  logic [31:0]      r_readdata;

  logic [KEY_W-1:0] w_stable_nxt;
  logic [KEY_W-1:0] w_press;
  logic [KEY_W-1:0] w_w1c;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  // Upper write-data bits are architecturally ignored.
  assign w_unused_wdata = ^avs_writedata;

  // Two-flop synchroniser on the inverted pins: 1 = pressed.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~key_n;
      r_sync2 <= r_sync1;
    end
  end

  // A bit is accepted once it has differed from the stable level for DEB_CYCLES samples.
  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < int'(KEY_W); i++) begin
      if ((r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX)) begin
        w_stable_nxt[i] = r_sync2[i];
      end
    end
  end

  assign w_press = w_stable_nxt & ~r_stable;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < int'(KEY_W); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_stable <= w_stable_nxt;
      for (int i = 0; i < int'(KEY_W); i++) begin
        if ((r_sync2[i] == r_stable[i]) || (r_cnt[i] == CNT_MAX)) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_w1c = (avs_write && (avs_address == ADDR_ECAP)) ? avs_writedata[KEY_W-1:0] : '0;

  // Read mux sees pre-write register values.
  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      ADDR_DATA: w_rd_mux = 32'(r_stable);
      ADDR_LED:  w_rd_mux = 32'(r_led);
      ADDR_MASK: w_rd_mux = 32'(r_mask);
      ADDR_ECAP: w_rd_mux = 32'(r_edge_cap);
      default:   w_rd_mux = '0;
    endcase
  end

  // A press landing in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_edge_cap <= '0;
      r_mask     <= '0;
      r_led      <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_edge_cap <= (r_edge_cap & ~w_w1c) | w_press;
      r_irq      <= |(r_edge_cap & r_mask);
      if (avs_write && (avs_address == ADDR_LED)) begin
        r_led <= avs_writedata[LED_W-1:0];
      end
      if (avs_write && (avs_address == ADDR_MASK)) begin
        r_mask <= avs_writedata[KEY_W-1:0];
      end
      if (avs_read) begin
        r_readdata <= w_rd_mux;
      end
    end
  end

  assign avs_readdata = r_readdata;
  assign irq          = r_irq;
  assign led          = r_led;

endmodule
